// File: rtl/pipeline_pkg.sv
// Constants shared by the fetch path: instruction width, PC step and default halt encoding.
// Pure declarations; no timing or flow control.
package pipeline_pkg;

    localparam int          INST_W            = 32;
    localparam int          PC_STEP           = 4;
    localparam logic [11:0] DEFAULT_HALT_CODE = 12'h300;

    function automatic logic is_halt(input logic [11:0] low_bits, input logic [11:0] code);
        return low_bits == code;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: DEPTH-entry circular buffer with synchronous clear.
// Latency: a push is visible at the head the next cycle. The head is read combinationally.
// Backpressure: a push is only written when a slot is free or a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_srst) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch unit: PC, credit-based fetch issue, redirect flush and halt detection ahead of ID.
// Latency: issue at N, push at N+1, instValid at N+2 when the queue is empty and ID is ready.
// Backpressure: instReady low holds the head; issue stops once queue entries plus the in-flight fetch reach DEPTH.
module pipeline_fetch_queue
    import pipeline_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 4,
    parameter logic [11:0] HALT_CODE = DEFAULT_HALT_CODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] startAddress,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [31:0]       imemData,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectTarget,
    output logic              instValid,
    input  logic              instReady,
    output logic [31:0]       instData,
    output logic [ADDR_W-1:0] pcPlus4Out,
    output logic              endProgram
);

    localparam int                CW       = $clog2(DEPTH) + 1;
    localparam int                EW       = INST_W + ADDR_W;
    localparam logic [CW:0]       LP_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inflight;
    logic              r_halt_pend;
    logic              r_end;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_push_halt;
    logic              w_pop_halt;
    logic              w_fifo_clr;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occ;
    logic [EW-1:0]     w_head;

    // The in-flight fetch already owns a slot, so it counts against the credit.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = !reset && (w_occ < LP_DEPTH) && !r_halt_pend && !r_end && !redirect;

    assign w_pop       = instValid && instReady;
    assign w_push      = r_inflight && !redirect && !r_end && !(w_full && !w_pop);
    assign w_push_halt = w_push && is_halt(imemData[11:0], HALT_CODE);
    assign w_pop_halt  = w_pop && is_halt(instData[11:0], HALT_CODE);
    assign w_fifo_clr  = reset || redirect;

    assign imemReq    = w_issue;
    assign imemAddr   = r_pc;
    assign instValid  = !reset && !w_empty;
    assign instData   = w_head[EW-1 -: INST_W];
    assign pcPlus4Out = w_head[ADDR_W-1:0];
    assign endProgram = r_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= startAddress;
            r_req_addr  <= '0;
            r_inflight  <= 1'b0;
            r_halt_pend <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_addr <= r_pc;
            end
            if (redirect) begin
                r_pc <= redirectTarget;
            end else if (w_issue) begin
                r_pc <= r_pc + LP_STEP;
            end
            // A redirect flushes the queue, so any halt word it held is gone too.
            if (redirect) begin
                r_halt_pend <= 1'b0;
            end else if (w_push_halt) begin
                r_halt_pend <= 1'b1;
            end
            if (w_pop_halt && !redirect) begin
                r_end <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .i_srst     (w_fifo_clr),
        .i_push     (w_push),
        .i_push_dat ({imemData, r_req_addr + LP_STEP}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Directed bench for pipeline_fetch_queue: vector table for streaming/stall/redirect,
// hand sequences for credit fill, halt, halt-vs-redirect and reset while halted.
module tb_pipeline_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] startAddress;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        instValid;
    logic        instReady;
    logic [31:0] instData;
    logic [31:0] pcPlus4Out;
    logic        endProgram;

    int total = 0;
    int bad   = 0;

    logic [31:0] halt_addr = 32'hFFFF_FFFF;
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    pipeline_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .startAddress   (startAddress),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemData       (imemData),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .instValid      (instValid),
        .instReady      (instReady),
        .instData       (instData),
        .pcPlus4Out     (pcPlus4Out),
        .endProgram     (endProgram)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return 32'h0000_0300;
        return {a[23:0], 8'h13};
    endfunction

    // Memory model: answers one cycle after a request with an address-derived word.
    always @(negedge clk) begin
        req_s  = imemReq;
        addr_s = imemAddr;
    end
    always @(posedge clk) begin
        mem_data <= req_s ? mem_word(addr_s) : 32'h0;
    end
    assign imemData = mem_data;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] sa);
        reset        = 1'b1;
        startAddress = sa;
        redirect     = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rdr;
        logic [31:0] tgt;
        logic        e_req;
        logic        ca;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc4;
        logic [31:0] e_dat;
        logic        e_end;
    } vec_t;

    vec_t v[15];

    initial begin
        int nreq;
        int npop;

        //          rst   rdy   rdr   tgt          req   ca    addr         vld   pc4          dat               end
        v[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     32'h0,          1'b0};
        v[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h100,   1'b0, 32'h0,     32'h0,          1'b0};
        v[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h104,   1'b0, 32'h0,     32'h0,          1'b0};
        v[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h108,   1'b1, 32'h104,   32'h0001_0013,  1'b0};
        v[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10C,   1'b1, 32'h108,   32'h0001_0413,  1'b0};
        v[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h110,   1'b1, 32'h10C,   32'h0001_0813,  1'b0};
        v[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     32'h0,          1'b0};
        v[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h100,   1'b0, 32'h0,     32'h0,          1'b0};
        v[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h104,   1'b0, 32'h0,     32'h0,          1'b0};
        v[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h108,   1'b1, 32'h104,   32'h0001_0013,  1'b0};
        v[10] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10C,   1'b1, 32'h104,   32'h0001_0013,  1'b0};
        v[11] = '{1'b0, 1'b0, 1'b1, 32'h400,   1'b0, 1'b1, 32'h110,   1'b1, 32'h104,   32'h0001_0013,  1'b0};
        v[12] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h400,   1'b0, 32'h0,     32'h0,          1'b0};
        v[13] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h404,   1'b0, 32'h0,     32'h0,          1'b0};
        v[14] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h408,   1'b1, 32'h404,   32'h0004_0013,  1'b0};

        reset          = 1'b1;
        startAddress   = 32'h100;
        redirect       = 1'b0;
        redirectTarget = 32'h0;
        instReady      = 1'b1;
        cyc();

        // Streaming from reset, reset with a non-empty queue, stall, then redirect.
        for (int i = 0; i < 15; i++) begin
            reset          = v[i].rst;
            instReady      = v[i].rdy;
            redirect       = v[i].rdr;
            redirectTarget = v[i].tgt;
            @(negedge clk);
            chk1($sformatf("row%0d_req", i), imemReq, v[i].e_req);
            chk1($sformatf("row%0d_vld", i), instValid, v[i].e_vld);
            chk1($sformatf("row%0d_end", i), endProgram, v[i].e_end);
            if (v[i].ca) chk32($sformatf("row%0d_addr", i), imemAddr, v[i].e_addr);
            if (v[i].e_vld) begin
                chk32($sformatf("row%0d_pc4", i), pcPlus4Out, v[i].e_pc4);
                chk32($sformatf("row%0d_dat", i), instData, v[i].e_dat);
            end
            cyc();
        end
        redirect = 1'b0;

        // Credit fill: ID stalled for 10 cycles, then released.
        instReady = 1'b0;
        do_reset(32'h100);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imemReq) nreq++;
            cyc();
        end
        chk32("stall_req_count", 32'(nreq), 32'd4);
        @(negedge clk);
        chk1("stall_req_low", imemReq, 1'b0);
        chk1("stall_head_vld", instValid, 1'b1);
        cyc();
        instReady = 1'b1;
        npop = 0;
        for (int i = 0; i < 20 && npop < 4; i++) begin
            @(negedge clk);
            if (instValid) begin
                chk32("drain_pc4", pcPlus4Out, 32'h104 + 32'(4 * npop));
                chk32("drain_dat", instData, mem_word(32'h100 + 32'(4 * npop)));
                npop++;
            end
            cyc();
        end
        chk32("drain_count", 32'(npop), 32'd4);

        // Halt word at 0x10C.
        halt_addr = 32'h10C;
        instReady = 1'b1;
        do_reset(32'h100);
        repeat (5) cyc();
        @(negedge clk);
        chk32("halt_head", instData, 32'h0000_0300);
        chk1("halt_head_vld", instValid, 1'b1);
        chk1("halt_no_issue", imemReq, 1'b0);
        chk1("halt_end_before_pop", endProgram, 1'b0);
        cyc();
        instReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("halt_end_sticky", endProgram, 1'b1);
            chk1("halt_req_off", imemReq, 1'b0);
            cyc();
        end
        chk1("halted_queue_nonempty", instValid, 1'b1);

        // Reset while halted with a word still queued.
        reset        = 1'b1;
        startAddress = 32'h180;
        @(negedge clk);
        chk1("rst_halted_req", imemReq, 1'b0);
        chk1("rst_halted_vld", instValid, 1'b0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_end", endProgram, 1'b0);
        chk1("post_rst_vld", instValid, 1'b0);
        chk1("post_rst_req", imemReq, 1'b1);
        chk32("post_rst_addr", imemAddr, 32'h180);
        cyc();

        // Halt word pushed in the same cycle as a redirect to 0x200.
        halt_addr = 32'h10C;
        instReady = 1'b1;
        do_reset(32'h100);
        repeat (4) cyc();
        redirect       = 1'b1;
        redirectTarget = 32'h200;
        @(negedge clk);
        chk1("rdh_vld", instValid, 1'b1);
        chk32("rdh_pc4", pcPlus4Out, 32'h10C);
        chk1("rdh_no_issue", imemReq, 1'b0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk1("rdh_end", endProgram, 1'b0);
        chk1("rdh_flushed", instValid, 1'b0);
        chk1("rdh_req", imemReq, 1'b1);
        chk32("rdh_addr", imemAddr, 32'h200);
        cyc();
        cyc();
        @(negedge clk);
        chk1("rdh_resume_vld", instValid, 1'b1);
        chk32("rdh_resume_pc4", pcPlus4Out, 32'h204);
        chk32("rdh_resume_dat", instData, 32'h0002_0013);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            chk1("rdh_end_stays_low", endProgram, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
